obi_mem_responder: RTL and testbench

// - Memory-side responder for the core's OBI-style req/gnt/rvalid interface (instr or data port).
// - Grants requests and applies byte-enabled writes to an internal word array.
// - Returns read data in request order after a fixed minimum latency.
// - Replaces unconstrained gnt/rvalid/rdata stimulus in formal and sim harnesses.
// - Two instances serve one core: one on the instruction port, one on the data port.

---
 rtl/obi_mem_responder_if.sv | 25 ++
 rtl/obi_mem_responder.sv | 113 +++++++++++
 tb/tb_obi_mem_responder.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/obi_mem_responder_if.sv
// Bus bundle between an OBI-style requester (core port or harness) and obi_mem_responder.
// The master drives request and stall fields; the responder drives gnt_o, rvalid_o and rdata_o.
interface obi_mem_responder_if #(
  parameter int ADDR_WIDTH = 32
) ();
  logic                  req_i;
  logic                  gnt_o;
  logic [ADDR_WIDTH-1:0] addr_i;
  logic                  we_i;
  logic [3:0]            be_i;
  logic [31:0]           wdata_i;
  logic                  rvalid_o;
  logic [31:0]           rdata_o;
  logic                  stall_i;

  modport master (
    output req_i, addr_i, we_i, be_i, wdata_i, stall_i,
    input  gnt_o, rvalid_o, rdata_o
  );

  modport slave (
    input  req_i, addr_i, we_i, be_i, wdata_i, stall_i,
    output gnt_o, rvalid_o, rdata_o
  );
endinterface

// File: rtl/obi_mem_responder.sv
// Memory-side OBI responder: grants requests and returns in-order responses after a minimum latency.
// Define OBI_RESP_RAND_STALL_EN to withhold the grant on pseudo-random cycles driven by an LFSR.
module obi_mem_responder #(
  parameter int ADDR_WIDTH      = 32,
  parameter int MEM_WORDS       = 1024,
  parameter int MAX_OUTSTANDING = 2,
  parameter int RVALID_LATENCY  = 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  obi_mem_responder_if.slave  bus
);
  localparam int         IDX_W = $clog2(MEM_WORDS);
  localparam int         PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int         CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [2:0] LAT   = 3'(RVALID_LATENCY);

  logic [31:0]           r_mem  [MEM_WORDS];
  logic [31:0]           r_data [MAX_OUTSTANDING];
  logic [2:0]            r_age  [MAX_OUTSTANDING];
  logic [PTR_W-1:0]      r_head;
  logic [PTR_W-1:0]      r_tail;
  logic [CNT_W-1:0]      r_count;

  logic [ADDR_WIDTH-1:0] w_addr;
  logic [IDX_W-1:0]      w_idx;
  logic [31:0]           w_pushData;
  logic                  w_randStall;
  logic                  w_full;
  logic                  w_gnt;
  logic                  w_accept;
  logic                  w_pop;
  logic                  w_unused;

  function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  // Upper address bits alias onto the array and the byte offset is irrelevant for word access.
  assign w_addr   = bus.addr_i;
  assign w_idx    = w_addr[2 +: IDX_W];
  assign w_unused = ^{w_addr[ADDR_WIDTH-1:IDX_W+2], w_addr[1:0]};

`ifdef OBI_RESP_RAND_STALL_EN
  logic [15:0] r_lfsr;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_lfsr <= 16'hACE1;
    end else begin
      r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
    end
  end

  assign w_randStall = r_lfsr[0] & r_lfsr[3];
`else
  assign w_randStall = 1'b0;
`endif

  // A slot freed by this cycle's pop only becomes grantable next cycle, so full uses the registered count.
  assign w_full     = (r_count == CNT_W'(MAX_OUTSTANDING));
  assign w_gnt      = rst_ni & bus.req_i & ~bus.stall_i & ~w_full & ~w_randStall;
  assign w_accept   = bus.req_i & w_gnt;
  assign w_pop      = (r_count != '0) && (r_age[r_head] == LAT);
  assign w_pushData = bus.we_i ? 32'h0 : r_mem[w_idx];

  assign bus.gnt_o    = w_gnt;
  assign bus.rvalid_o = w_pop;
  assign bus.rdata_o  = w_pop ? r_data[r_head] : 32'h0;

  // Memory contents survive reset; reads sample the pre-write value at the accepting edge.
  always_ff @(posedge clk_i) begin
    if (w_accept && bus.we_i) begin
      for (int k = 0; k < 4; k++) begin
        if (bus.be_i[k]) begin
          r_mem[w_idx][8*k +: 8] <= bus.wdata_i[8*k +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        r_data[i] <= 32'h0;
        r_age[i]  <= 3'd0;
      end
    end else begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        if (r_age[i] < LAT) begin
          r_age[i] <= r_age[i] + 3'd1;
        end
      end
      // The push overrides the generic age update of the tail slot.
      if (w_accept) begin
        r_data[r_tail] <= w_pushData;
        r_age[r_tail]  <= 3'd1;
        r_tail         <= nextPtr(r_tail);
      end
      if (w_pop) begin
        r_head <= nextPtr(r_head);
      end
      if (w_accept && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!w_accept && w_pop) begin
        r_count <= r_count - 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_obi_mem_responder.sv
// Testbench for obi_mem_responder: a queue-based model checks the default instance every cycle,
// and a second instance (MAX_OUTSTANDING=2, RVALID_LATENCY=3) is pinned by literal cycle expectations.
module tb_obi_mem_responder;
  localparam int MAX1 = 2;
  localparam int LAT1 = 1;

  logic clk_i = 1'b0;
  logic rst_ni;

  always #5 clk_i = ~clk_i;

  obi_mem_responder_if #(.ADDR_WIDTH(32)) bus1 ();
  obi_mem_responder_if #(.ADDR_WIDTH(32)) bus2 ();

  obi_mem_responder #(
    .ADDR_WIDTH(32), .MEM_WORDS(1024), .MAX_OUTSTANDING(MAX1), .RVALID_LATENCY(LAT1)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .bus(bus1)
  );

  obi_mem_responder #(
    .ADDR_WIDTH(32), .MEM_WORDS(1024), .MAX_OUTSTANDING(2), .RVALID_LATENCY(3)
  ) dutFull (
    .clk_i(clk_i), .rst_ni(rst_ni), .bus(bus2)
  );

  int testsRun    = 0;
  int testsFailed = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic idleBuses();
    bus1.req_i = 1'b0; bus1.we_i = 1'b0; bus1.addr_i = '0; bus1.be_i = '0; bus1.wdata_i = '0; bus1.stall_i = 1'b0;
    bus2.req_i = 1'b0; bus2.we_i = 1'b0; bus2.addr_i = '0; bus2.be_i = '0; bus2.wdata_i = '0; bus2.stall_i = 1'b0;
  endtask

  // Drives one cycle on the selected port (the other idles) and returns at the negedge for sampling.
  task automatic applyStimulus(input int port, input logic req, input logic we, input logic [31:0] addr,
                               input logic [3:0] be, input logic [31:0] wdata, input logic stall);
    @(posedge clk_i);
    #1;
    idleBuses();
    if (port == 1) begin
      bus1.req_i = req; bus1.we_i = we; bus1.addr_i = addr; bus1.be_i = be; bus1.wdata_i = wdata; bus1.stall_i = stall;
    end else begin
      bus2.req_i = req; bus2.we_i = we; bus2.addr_i = addr; bus2.be_i = be; bus2.wdata_i = wdata; bus2.stall_i = stall;
    end
    @(negedge clk_i);
  endtask

  task automatic idleCycle();
    applyStimulus(1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
  endtask

  // Reference model for the default instance: word memory plus a queue of responses with ready cycles.
  typedef struct {
    logic [31:0] data;
    longint      ready;
  } resp_t;

  resp_t       respQ[$];
  logic [31:0] modelMem [int];
  longint      cycleNum  = 0;
  logic        expAccept = 1'b0;
  logic        expPop    = 1'b0;
  logic        expGnt;
  logic [31:0] expData;
  logic        capWe;
  logic [31:0] capAddr;
  logic [31:0] capWdata;
  logic [3:0]  capBe;

  always @(negedge clk_i) begin
    if (!rst_ni) begin
      respQ.delete();
      expAccept = 1'b0;
      expPop    = 1'b0;
      checkOutput("model reset gnt", {31'h0, bus1.gnt_o}, 32'h0);
      checkOutput("model reset rvalid", {31'h0, bus1.rvalid_o}, 32'h0);
      checkOutput("model reset rdata", bus1.rdata_o, 32'h0);
    end else begin
      expGnt  = bus1.req_i && !bus1.stall_i && (respQ.size() < MAX1);
      expPop  = (respQ.size() > 0) && (cycleNum >= respQ[0].ready);
      expData = expPop ? respQ[0].data : 32'h0;
      checkOutput("model gnt", {31'h0, bus1.gnt_o}, {31'h0, expGnt});
      checkOutput("model rvalid", {31'h0, bus1.rvalid_o}, {31'h0, expPop});
      checkOutput("model rdata", bus1.rdata_o, expData);
      expAccept = bus1.req_i && expGnt;
      capWe     = bus1.we_i;
      capAddr   = bus1.addr_i;
      capWdata  = bus1.wdata_i;
      capBe     = bus1.be_i;
    end
  end

  always @(posedge clk_i) begin
    int          idx;
    logic [31:0] word;
    if (expPop) begin
      respQ.delete(0);
    end
    if (expAccept) begin
      idx = int'((capAddr / 4) % 1024);
      if (capWe) begin
        word = modelMem.exists(idx) ? modelMem[idx] : 32'h0;
        for (int k = 0; k < 4; k++) begin
          if (capBe[k]) word[8*k +: 8] = capWdata[8*k +: 8];
        end
        modelMem[idx] = word;
        respQ.push_back('{data: 32'h0, ready: cycleNum + LAT1});
      end else begin
        respQ.push_back('{data: (modelMem.exists(idx) ? modelMem[idx] : 32'hx), ready: cycleNum + LAT1});
      end
    end
    expAccept = 1'b0;
    expPop    = 1'b0;
    cycleNum++;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_ni = 1'b0;
    idleBuses();
    bus1.req_i = 1'b1;
    bus2.req_i = 1'b1;
    @(negedge clk_i);
    checkOutput("reset gnt dut1", {31'h0, bus1.gnt_o}, 32'h0);
    checkOutput("reset gnt dut2", {31'h0, bus2.gnt_o}, 32'h0);
    checkOutput("reset rvalid dut2", {31'h0, bus2.rvalid_o}, 32'h0);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    idleBuses();

    // Write then read on the default instance
    applyStimulus(1, 1'b1, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 1'b0);
    checkOutput("wr gnt", {31'h0, bus1.gnt_o}, 32'h1);
    checkOutput("wr no early rvalid", {31'h0, bus1.rvalid_o}, 32'h0);
    applyStimulus(1, 1'b1, 1'b0, 32'h10, 4'h0, 32'h0, 1'b0);
    checkOutput("rd gnt", {31'h0, bus1.gnt_o}, 32'h1);
    checkOutput("wr resp rvalid", {31'h0, bus1.rvalid_o}, 32'h1);
    checkOutput("wr resp rdata", bus1.rdata_o, 32'h0);
    idleCycle();
    checkOutput("rd resp rvalid", {31'h0, bus1.rvalid_o}, 32'h1);
    checkOutput("rd resp rdata", bus1.rdata_o, 32'hDEADBEEF);
    idleCycle();
    checkOutput("idle rvalid", {31'h0, bus1.rvalid_o}, 32'h0);

    // Partial write, then reads with and without a byte offset
    applyStimulus(1, 1'b1, 1'b1, 32'h10, 4'hF, 32'h11223344, 1'b0);
    applyStimulus(1, 1'b1, 1'b1, 32'h10, 4'b0101, 32'hAABBCCDD, 1'b0);
    applyStimulus(1, 1'b1, 1'b0, 32'h10, 4'h0, 32'h0, 1'b0);
    applyStimulus(1, 1'b1, 1'b0, 32'h13, 4'h0, 32'h0, 1'b0);
    checkOutput("partial write rdata", bus1.rdata_o, 32'h11BB33DD);
    idleCycle();
    checkOutput("byte offset ignored", bus1.rdata_o, 32'h11BB33DD);

    // Address aliasing past the array depth
    applyStimulus(1, 1'b1, 1'b1, 32'h0000_1004, 4'hF, 32'hCAFEF00D, 1'b0);
    applyStimulus(1, 1'b1, 1'b0, 32'h0000_0004, 4'h0, 32'h0, 1'b0);
    idleCycle();
    checkOutput("alias rdata", bus1.rdata_o, 32'hCAFEF00D);

    // Harness stall suppresses the grant
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 1'b1, 1'b0, 32'h4, 4'h0, 32'h0, 1'b1);
      checkOutput("stall gnt", {31'h0, bus1.gnt_o}, 32'h0);
    end
    applyStimulus(1, 1'b1, 1'b0, 32'h4, 4'h0, 32'h0, 1'b0);
    checkOutput("post stall gnt", {31'h0, bus1.gnt_o}, 32'h1);
    idleCycle();
    checkOutput("post stall rdata", bus1.rdata_o, 32'hCAFEF00D);

    // Latency-3 instance: preload two words and drain
    applyStimulus(2, 1'b1, 1'b1, 32'h20, 4'hF, 32'h12345678, 1'b0);
    applyStimulus(2, 1'b1, 1'b1, 32'h24, 4'hF, 32'h9ABCDEF0, 1'b0);
    idleCycle();
    checkOutput("lat3 not yet valid", {31'h0, bus2.rvalid_o}, 32'h0);
    idleCycle();
    checkOutput("lat3 wr resp rvalid", {31'h0, bus2.rvalid_o}, 32'h1);
    checkOutput("lat3 wr resp rdata", bus2.rdata_o, 32'h0);
    idleCycle();
    idleCycle();

    // FIFO full with req held over three reads
    applyStimulus(2, 1'b1, 1'b0, 32'h20, 4'h0, 32'h0, 1'b0);
    checkOutput("full c0 gnt", {31'h0, bus2.gnt_o}, 32'h1);
    applyStimulus(2, 1'b1, 1'b0, 32'h24, 4'h0, 32'h0, 1'b0);
    checkOutput("full c1 gnt", {31'h0, bus2.gnt_o}, 32'h1);
    checkOutput("full c1 rvalid", {31'h0, bus2.rvalid_o}, 32'h0);
    applyStimulus(2, 1'b1, 1'b0, 32'h20, 4'h0, 32'h0, 1'b0);
    checkOutput("full c2 gnt", {31'h0, bus2.gnt_o}, 32'h0);
    checkOutput("full c2 rvalid", {31'h0, bus2.rvalid_o}, 32'h0);
    applyStimulus(2, 1'b1, 1'b0, 32'h20, 4'h0, 32'h0, 1'b0);
    checkOutput("full c3 gnt", {31'h0, bus2.gnt_o}, 32'h0);
    checkOutput("full c3 rvalid", {31'h0, bus2.rvalid_o}, 32'h1);
    checkOutput("full c3 rdata", bus2.rdata_o, 32'h12345678);
    applyStimulus(2, 1'b1, 1'b0, 32'h20, 4'h0, 32'h0, 1'b0);
    checkOutput("full c4 gnt", {31'h0, bus2.gnt_o}, 32'h1);
    checkOutput("full c4 rvalid", {31'h0, bus2.rvalid_o}, 32'h1);
    checkOutput("full c4 rdata", bus2.rdata_o, 32'h9ABCDEF0);
    idleCycle();
    checkOutput("full c5 rvalid", {31'h0, bus2.rvalid_o}, 32'h0);
    idleCycle();
    checkOutput("full c6 rvalid", {31'h0, bus2.rvalid_o}, 32'h0);
    idleCycle();
    checkOutput("full c7 rvalid", {31'h0, bus2.rvalid_o}, 32'h1);
    checkOutput("full c7 rdata", bus2.rdata_o, 32'h12345678);
    idleCycle();

    // Reset while two responses are pending
    applyStimulus(2, 1'b1, 1'b0, 32'h20, 4'h0, 32'h0, 1'b0);
    applyStimulus(2, 1'b1, 1'b0, 32'h24, 4'h0, 32'h0, 1'b0);
    idleCycle();
    @(posedge clk_i);
    #1;
    rst_ni = 1'b0;
    idleBuses();
    bus2.req_i  = 1'b1;
    bus2.addr_i = 32'h20;
    @(negedge clk_i);
    checkOutput("mid reset gnt", {31'h0, bus2.gnt_o}, 32'h0);
    checkOutput("mid reset rvalid", {31'h0, bus2.rvalid_o}, 32'h0);
    checkOutput("mid reset rdata", bus2.rdata_o, 32'h0);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    idleBuses();
    @(negedge clk_i);
    checkOutput("post reset rvalid", {31'h0, bus2.rvalid_o}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      idleCycle();
      checkOutput("post reset no stale rvalid", {31'h0, bus2.rvalid_o}, 32'h0);
    end
    applyStimulus(2, 1'b1, 1'b0, 32'h24, 4'h0, 32'h0, 1'b0);
    checkOutput("post reset gnt", {31'h0, bus2.gnt_o}, 32'h1);
    idleCycle();
    idleCycle();
    checkOutput("post reset early rvalid", {31'h0, bus2.rvalid_o}, 32'h0);
    idleCycle();
    checkOutput("post reset rvalid", {31'h0, bus2.rvalid_o}, 32'h1);
    checkOutput("post reset rdata", bus2.rdata_o, 32'h9ABCDEF0);
    idleCycle();
    idleCycle();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end
endmodule
